instr_fetch_unit: RTL

- Read side of the instruction memory that the program loader writes through addr/wEn/wDat.
- Once working is high, it walks a PC from address 0 and issues synchronous reads.
- It decodes each 32-bit word into icode/ifun/rA/rB/imm and hands each decoded instruction to the execute stage over a valid/ready handshake.
- Stops on HALT, on an illegal opcode, or when working drops.

---
 rtl/instr_fetch_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: walks a PC through instruction memory, decodes each word and hands it
// to execute over valid/ready. Define FETCH_TRACE_EN to add the instr_count handshake counter.
module instr_fetch_unit #(
  parameter int unsigned AW       = 9,
  parameter int unsigned IMEM_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          working,
  output logic [AW-1:0] imem_addr,
  output logic          imem_ren,
  input  logic [31:0]   imem_rdat,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    icode,
  output logic [3:0]    ifun,
  output logic [7:0]    ra,
  output logic [7:0]    rb,
  output logic [15:0]   imm,
  output logic [AW-1:0] instr_pc,
  output logic          halted,
  output logic          illegal
`ifdef FETCH_TRACE_EN
  ,
  output logic [15:0]   instr_count
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StOut,
    StStop
  } fetchStateE;

  fetchStateE    state;
  logic [AW-1:0] pc;
  logic [1:0]    waitCnt;
  logic          lastWait;

  assign imem_addr = pc;
  assign lastWait  = (waitCnt == 2'(IMEM_LAT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= StIdle;
      pc        <= '0;
      waitCnt   <= '0;
      imem_ren  <= 1'b0;
      out_valid <= 1'b0;
      icode     <= '0;
      ifun      <= '0;
      ra        <= '0;
      rb        <= '0;
      imm       <= '0;
      instr_pc  <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
`ifdef FETCH_TRACE_EN
      instr_count <= '0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          pc <= '0;
          if (working) begin
            state    <= StReq;
            imem_ren <= 1'b1;
          end
        end

        StReq: begin
          imem_ren <= 1'b0;
          if (!working) begin
            state     <= StIdle;
            pc        <= '0;
            out_valid <= 1'b0;
`ifdef FETCH_TRACE_EN
            instr_count <= '0;
`endif
          end else begin
            state   <= StWait;
            waitCnt <= '0;
          end
        end

        StWait: begin
          // Abort drops the in-flight read; its data is never latched.
          if (!working) begin
            state     <= StIdle;
            pc        <= '0;
            out_valid <= 1'b0;
`ifdef FETCH_TRACE_EN
            instr_count <= '0;
`endif
          end else if (lastWait) begin
            icode     <= imem_rdat[31:28];
            ifun      <= imem_rdat[27:24];
            ra        <= imem_rdat[23:16];
            rb        <= imem_rdat[15:8];
            imm       <= imem_rdat[15:0];
            instr_pc  <= pc;
            out_valid <= 1'b1;
            state     <= StOut;
          end else begin
            waitCnt <= waitCnt + 2'd1;
          end
        end

        StOut: begin
          // Abort outranks acceptance, so the presented word is not consumed.
          if (!working) begin
            state     <= StIdle;
            pc        <= '0;
            out_valid <= 1'b0;
`ifdef FETCH_TRACE_EN
            instr_count <= '0;
`endif
          end else if (out_ready) begin
            out_valid <= 1'b0;
`ifdef FETCH_TRACE_EN
            if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
`endif
            if (icode == 4'd0) begin
              state  <= StStop;
              halted <= 1'b1;
            end else if (icode >= 4'd4) begin
              state   <= StStop;
              halted  <= 1'b1;
              illegal <= 1'b1;
            end else begin
              pc       <= pc + AW'(1);
              state    <= StReq;
              imem_ren <= 1'b1;
            end
          end
        end

        StStop: begin
          if (!working) begin
            state   <= StIdle;
            pc      <= '0;
            halted  <= 1'b0;
            illegal <= 1'b0;
`ifdef FETCH_TRACE_EN
            instr_count <= '0;
`endif
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule
